// File: rtl/atm_pkg.sv
// Shared constants and types for the ATM keypad front end.
package atm_pkg;

    localparam logic [3:0] KEY_ENTER  = 4'hA;
    localparam logic [3:0] KEY_CANCEL = 4'hB;
    localparam logic [3:0] KEY_DEP    = 4'hC;
    localparam logic [3:0] KEY_WD     = 4'hD;

    localparam logic [1:0] SEL_DEP = 2'b00;
    localparam logic [1:0] SEL_WD  = 2'b01;

    localparam int MAX_FAILS_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PIN,
        ST_SEL,
        ST_AMT,
        ST_REQ,
        ST_WAIT_RSP,
        ST_LOCK
    } state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/atm_amt_accum.sv
// Decimal amount accumulator: acc = acc*10 + digit, saturating into a sticky
// overflow flag once the value would leave the AMT_W-bit range.
module atm_amt_accum
    import atm_pkg::*;
#(
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             dig_stb_i,
    input  logic [3:0]       dig_val_i,
    output logic [AMT_W-1:0] acc_o,
    output logic             ovf_o,
    output logic             have_digit_o
);

    // acc*10 + 9 stays below 16 * 2^AMT_W, so four extra bits hold the product.
    localparam int PW = AMT_W + 4;
    localparam logic [PW-1:0] AMT_MAX = {4'b0000, {AMT_W{1'b1}}};

    logic [AMT_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             have_q, have_d;
    logic [PW-1:0]    acc_ext;
    logic [PW-1:0]    prod;

    assign acc_ext = {4'b0000, acc_q};
    assign prod    = (acc_ext << 3) + (acc_ext << 1) + {{AMT_W{1'b0}}, dig_val_i};

    // Next accumulator value; clear wins over a digit, overflow freezes acc.
    always_comb begin
        acc_d  = acc_q;
        ovf_d  = ovf_q;
        have_d = have_q;
        if (clr_i) begin
            acc_d  = '0;
            ovf_d  = 1'b0;
            have_d = 1'b0;
        end else if (dig_stb_i) begin
            have_d = 1'b1;
            if (!ovf_q) begin
                if (prod > AMT_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    acc_d = prod[AMT_W-1:0];
                end
            end
        end
    end

    // Accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            have_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            ovf_q  <= ovf_d;
            have_q <= have_d;
        end
    end

    assign acc_o        = acc_q;
    assign ovf_o        = ovf_q;
    assign have_digit_o = have_q;

endmodule

// File: rtl/atm_keypad_front.sv
// Keypad session front end: collects PIN, operation and amount, issues one
// valid/ready request, tracks consecutive wrong-PIN answers and locks out.
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_IDLE     | waiting for the first PIN digit
// ST_PIN      | PIN digit held, ENTER advances, digits overwrite
// ST_SEL      | waiting for DEPOSIT or WITHDRAW
// ST_AMT      | collecting decimal amount digits
// ST_REQ      | request presented, waiting for req_ready
// ST_WAIT_RSP | request taken, waiting for controller response
// ST_LOCK     | too many wrong PINs; only reset leaves
module atm_keypad_front
    import atm_pkg::*;
#(
    parameter int AMT_W     = 4,
    parameter int MAX_FAILS = MAX_FAILS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid_i,
    input  logic [3:0]       key_code_i,
    output logic             req_valid_o,
    input  logic             req_ready_i,
    output logic [3:0]       req_pin_o,
    output logic [1:0]       req_sel_o,
    output logic [AMT_W-1:0] req_amt_o,
    input  logic             rsp_valid_i,
    input  logic             rsp_pin_ok_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [1:0]       fail_cnt_o,
    output logic             locked_o
);

    state_t     state_q, state_d;
    logic [3:0] pin_q, pin_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] fail_q, fail_d;
    logic       req_valid_q, req_valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       locked_q, locked_d;

    logic       acc_clr;
    logic       dig_stb;
    logic       acc_ovf;
    logic       acc_have;

    logic       key_dig, key_ent, key_can, key_dep, key_wd;

    assign key_dig = key_valid_i && is_digit(key_code_i);
    assign key_ent = key_valid_i && (key_code_i == KEY_ENTER);
    assign key_can = key_valid_i && (key_code_i == KEY_CANCEL);
    assign key_dep = key_valid_i && (key_code_i == KEY_DEP);
    assign key_wd  = key_valid_i && (key_code_i == KEY_WD);

    atm_amt_accum #(
        .AMT_W(AMT_W)
    ) u_accum (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (acc_clr),
        .dig_stb_i   (dig_stb),
        .dig_val_i   (key_code_i),
        .acc_o       (req_amt_o),
        .ovf_o       (acc_ovf),
        .have_digit_o(acc_have)
    );

    // Next state, session registers and registered-output decode.
    always_comb begin
        state_d = state_q;
        pin_d   = pin_q;
        sel_d   = sel_q;
        fail_d  = fail_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        acc_clr = 1'b0;
        dig_stb = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (key_dig) begin
                    pin_d   = key_code_i;
                    state_d = ST_PIN;
                end
            end
            ST_PIN: begin
                if (key_dig) begin
                    pin_d = key_code_i;
                end else if (key_ent) begin
                    state_d = ST_SEL;
                end else if (key_can) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEL: begin
                if (key_dep) begin
                    sel_d   = SEL_DEP;
                    state_d = ST_AMT;
                end else if (key_wd) begin
                    sel_d   = SEL_WD;
                    state_d = ST_AMT;
                end else if (key_can) begin
                    state_d = ST_IDLE;
                end
            end
            ST_AMT: begin
                if (key_dig) begin
                    dig_stb = 1'b1;
                end else if (key_ent) begin
                    if (!acc_have || acc_ovf) begin
                        err_d   = 1'b1;
                        acc_clr = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
                end else if (key_can) begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (req_ready_i) begin
                    state_d = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (rsp_valid_i) begin
                    if (rsp_pin_ok_i) begin
                        fail_d  = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        fail_d = fail_q + 2'd1;
                        if (int'(fail_d) == MAX_FAILS) begin
                            state_d = ST_LOCK;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_LOCK: begin
                state_d = ST_LOCK;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Any return to IDLE wipes the partial entry; the fail count survives.
        if (state_d == ST_IDLE) begin
            pin_d   = '0;
            acc_clr = 1'b1;
        end

        req_valid_d = (state_d == ST_REQ);
        busy_d      = (state_d == ST_REQ) || (state_d == ST_WAIT_RSP);
        locked_d    = (state_d == ST_LOCK);
    end

    // State and output registers; reset drops any in-flight request at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pin_q       <= '0;
            sel_q       <= '0;
            fail_q      <= '0;
            req_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pin_q       <= pin_d;
            sel_q       <= sel_d;
            fail_q      <= fail_d;
            req_valid_q <= req_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            locked_q    <= locked_d;
        end
    end

    assign req_valid_o = req_valid_q;
    assign req_pin_o   = pin_q;
    assign req_sel_o   = sel_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign fail_cnt_o  = fail_q;
    assign locked_o    = locked_q;

endmodule

// File: doc/atm_keypad_front.md
# atm_keypad_front

Keypad session front end for the ATM controller. It turns a stream of single-key events into one complete transaction: a PIN digit, an operation select, and a decimal amount. It presents that transaction to the account controller over a valid/ready request, waits for the controller's response, and tracks wrong-PIN attempts. After three consecutive failures it locks the terminal until reset.

## Interface
Parameters:
- AMT_W, 4: width of the request amount; the maximum accepted amount is 2^AMT_W-1.
- MAX_FAILS, 3: number of consecutive wrong-PIN responses that causes lockout.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_valid  in  1  one-cycle key event strobe.
- key_code  in  4  key code: 0-9 digit, A ENTER, B CANCEL, C DEPOSIT, D WITHDRAW, E/F ignored.
- req_valid  out  1  transaction request to the controller.
- req_ready  in  1  controller accepts the request.
- req_pin  out  4  entered PIN digit.
- req_sel  out  2  00 deposit, 01 withdraw.
- req_amt  out  AMT_W  entered amount.
- rsp_valid  in  1  one-cycle controller response strobe.
- rsp_pin_ok  in  1  qualified by rsp_valid; 1 means the PIN matched.
- busy  out  1  high in REQ and WAIT_RSP.
- done  out  1  one-cycle pulse on an accepted transaction (rsp_pin_ok=1).
- err  out  1  one-cycle pulse on a rejected amount entry.
- fail_cnt  out  2  count of consecutive wrong PINs.
- locked  out  1  terminal locked.

## Operation
- States: IDLE, PIN, SEL, AMT, REQ, WAIT_RSP, LOCK.
- IDLE: a digit stores pin_r and moves to PIN. All other keys are ignored.
- PIN: a digit overwrites pin_r. ENTER moves to SEL. CANCEL moves to IDLE.
- SEL: DEPOSIT sets sel_r=00 and moves to AMT. WITHDRAW sets sel_r=01 and moves to AMT. CANCEL moves to IDLE. Digits and ENTER are ignored.
- AMT: a digit updates acc = acc*10 + d and sets have_digit.
  - The accumulator is wide enough to hold the product before the compare.
  - If acc would exceed 2^AMT_W-1, the ovf flag sets and stays set; acc is frozen.
- AMT, ENTER:
  - If have_digit=0 or ovf=1: pulse err, clear acc/ovf/have_digit, and stay in AMT.
  - Otherwise: move to REQ.
- AMT, CANCEL: move to IDLE.
- REQ: hold req_valid=1 with req_pin/req_sel/req_amt stable until the cycle where req_ready=1, then move to WAIT_RSP.
- WAIT_RSP: wait for rsp_valid.
  - rsp_pin_ok=1: clear fail_cnt, pulse done, move to IDLE.
  - rsp_pin_ok=0: increment fail_cnt. If the new count equals MAX_FAILS, move to LOCK; otherwise move to IDLE.
- LOCK: locked=1. All keys and responses are ignored; only rst_n exits.
- Key events in REQ, WAIT_RSP and LOCK are dropped, not queued.
- Entering IDLE clears pin_r, acc, ovf and have_digit. fail_cnt is kept.
- CANCEL never changes fail_cnt.
- rsp_valid outside WAIT_RSP is ignored.

## Timing
- Every output is registered.
- Reset values: all outputs are 0, and the state is IDLE.
- Key to state change: a key sampled at edge n takes effect at edge n; outputs reflect it in cycle n+1.
- Request latency: req_valid rises in the cycle after ENTER in AMT is sampled.
- Handshake rules:
  - Transfer occurs on the edge where req_valid & req_ready are both high.
  - req_valid falls in the following cycle.
  - The earliest accepted rsp_valid is one cycle after the transfer.
- req_ready already high when REQ is entered: the transfer completes in the first REQ cycle, so req_valid is high for exactly one cycle.
- Lockout latency: locked rises one cycle after the failing rsp_valid that makes the count reach MAX_FAILS.
- Reset mid-operation: asserting rst_n low abandons any in-flight request immediately. req_valid drops asynchronously, and fail_cnt returns to 0.

## Structure
- Package atm_pkg holds:
  - key code constants (KEY_ENTER=4'hA, KEY_CANCEL=4'hB, KEY_DEP=4'hC, KEY_WD=4'hD);
  - SEL_DEP=2'b00 and SEL_WD=2'b01;
  - the state enum typedef;
  - the default MAX_FAILS.
- One sub-module, atm_amt_accum, implements the decimal accumulator.
  - Inputs: clear, digit strobe, digit value.
  - Outputs: acc[AMT_W-1:0], ovf, have_digit.
  - It is parameterised by AMT_W.
- The FSM, fail counter and handshake registers live in atm_keypad_front.

## Test plan
- Happy path: keys 7, A, D, 1, 2, A with req_ready=1 → req_valid for 1 cycle carrying pin=7, sel=01, amt=12. Then rsp_valid with pin_ok=1 → done pulse, state IDLE, fail_cnt=0.
- Overflow: keys 3, A, C, 1, 6, A → err pulse and no request. Then 9, A → request with amt=9 and sel=00.
- Backpressure: hold req_ready=0 for 5 cycles while sending keys 5 and A → req fields stable and keys ignored. Raise req_ready → single transfer.
- Lockout: three transactions each answered pin_ok=0 → fail_cnt goes 1, 2, 3, then locked=1. Further keys and responses produce no request. rst_n low → all outputs return to 0.
- Cancel and ignore: B in SEL returns to IDLE with fail_cnt unchanged. ENTER in IDLE is ignored. A digit in SEL is ignored. rsp_valid in IDLE is ignored.
- Reset during REQ: rst_n low while req_valid=1 → req_valid falls asynchronously, and the state is IDLE after release.
